jtag_tap_param: RTL and testbench

Parametrised IEEE 1149.1 TAP controller; successor to the fixed 5-bit-IR `tap_top`. It decodes TMS through the 16-state TAP FSM and holds an IR of configurable width. It implements IDCODE and BYPASS internally and routes up to `N_DR` external data registers (memory, FIFO, confreg, clk-bypass, observe, PMU, …) through one-hot selects and a TDO mux. It sits between the chip JTAG pins and the secured-bitstream configuration registers.

---
 rtl/jtag_pkg.sv | 36 +++
 rtl/jtag_tap_fsm.sv | 67 ++++++
 rtl/jtag_tap_param.sv | 131 +++++++++++++
 tb/tb_jtag_tap_param.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared TAP state encodings and constants for the JTAG TAP.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    localparam int IDCODE_W = 32;

    // IEEE 1149.1 state encodings
    typedef enum logic [3:0] {
        ST_EXIT2_DR = 4'h0,
        ST_EXIT1_DR = 4'h1,
        ST_SHIFT_DR = 4'h2,
        ST_PAUSE_DR = 4'h3,
        ST_SEL_IR   = 4'h4,
        ST_UPD_DR   = 4'h5,
        ST_CAP_DR   = 4'h6,
        ST_SEL_DR   = 4'h7,
        ST_EXIT2_IR = 4'h8,
        ST_EXIT1_IR = 4'h9,
        ST_SHIFT_IR = 4'hA,
        ST_PAUSE_IR = 4'hB,
        ST_RTI      = 4'hC,
        ST_UPD_IR   = 4'hD,
        ST_CAP_IR   = 4'hE,
        ST_TLR      = 4'hF
    } tap_state_t;

    function automatic logic [31:0] BYPASS_OP(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_fsm
// Description : 16-state TAP controller state register and phase decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tms,
    output tap_state_t o_state,
    output logic       o_tlr,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_update_dr,
    output logic       o_capture_ir,
    output logic       o_shift_ir,
    output logic       o_update_ir
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_TLR:      w_next = i_tms ? ST_TLR      : ST_RTI;
            ST_RTI:      w_next = i_tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   w_next = i_tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   w_next = i_tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: w_next = i_tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: w_next = i_tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: w_next = i_tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: w_next = i_tms ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   w_next = i_tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   w_next = i_tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   w_next = i_tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: w_next = i_tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: w_next = i_tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: w_next = i_tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: w_next = i_tms ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   w_next = i_tms ? ST_SEL_DR   : ST_RTI;
            default:     w_next = ST_TLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_state      = r_state;
    assign o_tlr        = (r_state == ST_TLR);
    assign o_capture_dr = (r_state == ST_CAP_DR);
    assign o_shift_dr   = (r_state == ST_SHIFT_DR);
    assign o_update_dr  = (r_state == ST_UPD_DR);
    assign o_capture_ir = (r_state == ST_CAP_IR);
    assign o_shift_ir   = (r_state == ST_SHIFT_IR);
    assign o_update_ir  = (r_state == ST_UPD_IR);

endmodule
`default_nettype wire

// File: rtl/jtag_tap_param.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_param
// Description : Parametrised TAP: IR, IDCODE/BYPASS DRs, channel decode, TDO mux.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int                     IR_W       = 5,
    parameter int                     N_DR       = 8,
    parameter logic [IDCODE_W-1:0]    IDCODE_VAL = 32'h1000_0045,
    parameter logic [IR_W-1:0]        OP_IDCODE  = 5'b00010,
    parameter logic [N_DR*IR_W-1:0]   DR_OPCODES = {5'h0B, 5'h0A, 5'h09, 5'h08,
                                                    5'h07, 5'h06, 5'h05, 5'h04}
) (
    input  logic            tck_i,
    input  logic            rst_i,
    input  logic            tms_i,
    input  logic            td_i,
    output logic            td_o,
    output logic            tdo_en_o,
    output logic            scan_in_o,
    output logic            capture_dr_o,
    output logic            shift_dr_o,
    output logic            update_dr_o,
    output logic [N_DR-1:0] dr_sel_o,
    input  logic [N_DR-1:0] dr_tdo_i,
    output logic [IR_W-1:0] ir_o,
    output logic [3:0]      tap_state_o
);

    localparam logic [IR_W-1:0] c_bypass_op = IR_W'(BYPASS_OP(IR_W));

    tap_state_t            w_state;
    logic                  w_tlr;
    logic                  w_capture_ir;
    logic                  w_shift_ir;
    logic                  w_update_ir;
    logic [IR_W-1:0]       r_ir_q;
    logic [IR_W-1:0]       r_ir_sr;
    logic [IDCODE_W-1:0]   r_idcode_sr;
    logic                  r_bypass;
    logic                  w_sel_idcode;
    logic [N_DR-1:0]       w_dr_sel;
    logic                  w_tdo;

    jtag_tap_fsm u_fsm (
        .clk          (tck_i),
        .rst          (rst_i),
        .i_tms        (tms_i),
        .o_state      (w_state),
        .o_tlr        (w_tlr),
        .o_capture_dr (capture_dr_o),
        .o_shift_dr   (shift_dr_o),
        .o_update_dr  (update_dr_o),
        .o_capture_ir (w_capture_ir),
        .o_shift_ir   (w_shift_ir),
        .o_update_ir  (w_update_ir)
    );

    // Descending scan so the lowest matching channel overwrites any higher one
    always_comb begin
        w_sel_idcode = 1'b0;
        w_dr_sel     = '0;
        if (r_ir_q == OP_IDCODE) begin
            w_sel_idcode = 1'b1;
        end else if (r_ir_q != c_bypass_op) begin
            for (int k = N_DR - 1; k >= 0; k--) begin
                if (r_ir_q == DR_OPCODES[k*IR_W +: IR_W]) begin
                    w_dr_sel    = '0;
                    w_dr_sel[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge tck_i) begin
        if (rst_i || w_tlr) begin
            r_ir_q  <= OP_IDCODE;
            r_ir_sr <= '0;
        end else if (w_capture_ir) begin
            r_ir_sr <= IR_W'(2'b01);
        end else if (w_shift_ir) begin
            r_ir_sr <= {td_i, r_ir_sr[IR_W-1:1]};
        end else if (w_update_ir) begin
            r_ir_q  <= r_ir_sr;
        end
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            r_idcode_sr <= '0;
            r_bypass    <= 1'b0;
        end else if (capture_dr_o) begin
            if (w_sel_idcode) begin
                r_idcode_sr <= IDCODE_VAL;
            end
            r_bypass <= 1'b0;
        end else if (shift_dr_o) begin
            if (w_sel_idcode) begin
                r_idcode_sr <= {td_i, r_idcode_sr[IDCODE_W-1:1]};
            end
            r_bypass <= td_i;
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        if (w_shift_ir) begin
            w_tdo = r_ir_sr[0];
        end else if (shift_dr_o) begin
            if (w_sel_idcode) begin
                w_tdo = r_idcode_sr[0];
            end else if (|w_dr_sel) begin
                w_tdo = |(dr_tdo_i & w_dr_sel);
            end else begin
                w_tdo = r_bypass;
            end
        end
    end

    assign td_o        = w_tdo;
    assign tdo_en_o    = w_shift_ir | shift_dr_o;
    assign scan_in_o   = td_i;
    assign dr_sel_o    = w_dr_sel;
    assign ir_o        = r_ir_q;
    assign tap_state_o = w_state;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_param
// Description : Directed bench for jtag_tap_param with hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_param;

    logic       tck_i = 1'b0;
    logic       rst_i;
    logic       tms_i;
    logic       td_i;
    logic       td_o;
    logic       tdo_en_o;
    logic       scan_in_o;
    logic       capture_dr_o;
    logic       shift_dr_o;
    logic       update_dr_o;
    logic [7:0] dr_sel_o;
    logic [7:0] dr_tdo_i;
    logic [4:0] ir_o;
    logic [3:0] tap_state_o;

    int checks   = 0;
    int failures = 0;
    int upd_seen = 0;
    logic upd_watch = 1'b0;

    jtag_tap_param dut (
        .tck_i        (tck_i),
        .rst_i        (rst_i),
        .tms_i        (tms_i),
        .td_i         (td_i),
        .td_o         (td_o),
        .tdo_en_o     (tdo_en_o),
        .scan_in_o    (scan_in_o),
        .capture_dr_o (capture_dr_o),
        .shift_dr_o   (shift_dr_o),
        .update_dr_o  (update_dr_o),
        .dr_sel_o     (dr_sel_o),
        .dr_tdo_i     (dr_tdo_i),
        .ir_o         (ir_o),
        .tap_state_o  (tap_state_o)
    );

    always #5 tck_i = ~tck_i;

    always @(negedge tck_i) begin
        if (upd_watch && update_dr_o) upd_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        tms_i = tms;
        td_i  = tdi;
        @(posedge tck_i);
        #1;
    endtask

    // From Run-Test/Idle: scan op into IR, return to Run-Test/Idle
    task automatic ir_scan(input logic [4:0] op, input logic [4:0] exp_cap,
                           input logic [4:0] exp_old);
        logic [4:0] cap;
        cap = '0;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("ir_shift_state", tap_state_o, 4'hA);
        for (int i = 0; i < 5; i++) begin
            cap[i] = td_o;
            step(i == 4, op[i]);
        end
        chk("ir_capture_bits", cap, exp_cap);
        step(1, 0);
        chk("upd_ir_state", tap_state_o, 4'hD);
        chk("ir_held_in_upd_ir", ir_o, exp_old);
        step(0, 0);
        chk("ir_after_update", ir_o, op);
    endtask

    initial begin
        logic [31:0] idc;
        logic [3:0]  tdi_seq;
        logic [3:0]  tdo_exp;
        rst_i = 1'b1; tms_i = 1'b1; td_i = 1'b0; dr_tdo_i = '0;
        step(1, 0); step(1, 0);
        chk("rst_state", tap_state_o, 4'hF);
        chk("rst_ir", ir_o, 5'b00010);
        chk("rst_dr_sel", dr_sel_o, 8'h00);
        chk("rst_td_o", td_o, 1'b0);
        chk("rst_tdo_en", tdo_en_o, 1'b0);
        chk("rst_strobes", {capture_dr_o, shift_dr_o, update_dr_o}, 3'b000);
        rst_i = 1'b0;

        // IDCODE read
        step(0, 0);
        chk("rti_state", tap_state_o, 4'hC);
        step(1, 0); step(0, 0);
        chk("cap_dr_strobe", {tap_state_o, capture_dr_o, shift_dr_o}, {4'h6, 2'b10});
        step(0, 0);
        chk("shift_dr_strobe", {tap_state_o, capture_dr_o, shift_dr_o, tdo_en_o}, {4'h2, 3'b011});
        td_i = 1'b1;
        #1;
        chk("scan_in_fwd", scan_in_o, 1'b1);
        idc = '0;
        for (int i = 0; i < 32; i++) begin
            idc[i] = td_o;
            step(i == 31, 0);
        end
        chk("idcode_value", idc, 32'h1000_0045);
        chk("exit1_dr_tdo", {tap_state_o, tdo_en_o, td_o}, {4'h1, 2'b00});
        step(1, 0);
        chk("upd_dr_strobe", {tap_state_o, update_dr_o}, {4'h5, 1'b1});
        step(0, 0);
        chk("upd_dr_one_cycle", update_dr_o, 1'b0);

        // External channel 0
        ir_scan(5'b00100, 5'b00001, 5'b00010);
        chk("dr_sel_ch0", dr_sel_o, 8'b0000_0001);
        step(1, 0); step(0, 0); step(0, 0);
        dr_tdo_i = 8'h01;
        #1;
        chk("ext_tdo_one", td_o, 1'b1);
        dr_tdo_i = 8'hFE;
        #1;
        chk("ext_tdo_other_masked", td_o, 1'b0);
        step(1, 0); step(1, 0); step(0, 0);
        chk("dr_sel_stable", dr_sel_o, 8'b0000_0001);

        // BYPASS and unmatched opcode
        ir_scan(5'b11111, 5'b00001, 5'b00100);
        chk("dr_sel_bypass", dr_sel_o, 8'h00);
        ir_scan(5'b10101, 5'b00001, 5'b11111);
        chk("dr_sel_unmatched", dr_sel_o, 8'h00);
        dr_tdo_i = 8'hFF;
        step(1, 0); step(0, 0); step(0, 0);
        tdi_seq = 4'b1101;   // applied LSB first: 1,0,1,1
        tdo_exp = 4'b1010;   // observed LSB first: 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bypass_tdo_%0d", i), td_o, tdo_exp[i]);
            step(0, tdi_seq[i]);
        end
        step(1, 0); step(0, 0);
        chk("pause_dr_state", {tap_state_o, tdo_en_o, td_o}, {4'h3, 2'b00});

        // TMS reset: four ones are not enough, the fifth reaches TLR
        for (int i = 0; i < 4; i++) step(1, 0);
        chk("tms4_not_tlr", tap_state_o, 4'h4);
        step(1, 0);
        chk("tms5_tlr", tap_state_o, 4'hF);
        step(1, 0);
        chk("tlr_ir_idcode", {tap_state_o, ir_o}, {4'hF, 5'b00010});
        chk("tlr_dr_sel", dr_sel_o, 8'h00);

        // Reset in the third Shift-IR cycle
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        upd_watch = 1'b1;
        step(0, 1); step(0, 1);
        chk("mid_ir_shift", tap_state_o, 4'hA);
        rst_i = 1'b1;
        step(0, 1);
        rst_i = 1'b0;
        chk("mid_rst_state", tap_state_o, 4'hF);
        chk("mid_rst_ir", ir_o, 5'b00010);
        step(0, 0); step(0, 0);
        chk("mid_rst_ir_later", {tap_state_o, ir_o}, {4'hC, 5'b00010});
        chk("mid_rst_no_update", upd_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
